md5_result_reporter: RTL and testbench
======================================

# md5_result_reporter

Downstream of the dual-core MD5 search FSM, between it and the `usart` transmitter. It latches the matching plaintext and digest when the search reports a hit. It then streams a framed ASCII report, byte by byte, over the USART's single-byte send/ready handshake. It replaces ad-hoc byte shifting in the search FSM and supports re-transmission on request.

## Interface
- `TEXT_BYTES`, default 8: plaintext width in bytes.
- `HASH_BITS`, default 128: digest width; must be a multiple of 4.
- `clk` in, 1: system clock.
- `reset` in, 1: reset, asynchronous, active-high.
- `found_valid` in, 1: one-cycle (or longer) hit strobe from the search FSM.
- `found_text` in, 8*TEXT_BYTES: candidate plaintext. Bits [63:56] are the first character.
- `found_hash` in, HASH_BITS: matching digest. Bit [127] is the MSB of the first digest nibble.
- `rewind` in, 1: request re-transmission of the latched report.
- `tx_data` out, 8: byte presented to the USART.
- `tx_send` out, 1: one-cycle send pulse.
- `tx_ready` in, 1: USART idle/accepting; high when a new byte may be sent.
- `busy` out, 1: report transmission in progress.
- `done` out, 1: the full report has been sent at least once since the last latch.

## Operation
- **Message:** `"K="`, then the plaintext bytes, then `" H="`, then HASH_BITS/4 lowercase hex chars, then CR (0x0D), LF (0x0A). Maximum length is 47 bytes with the default parameters.
- **Plaintext:** sent first-character first. Leading 0x00 bytes are skipped, consistent with the generator's variable-length candidates. Zeros after the first nonzero byte are sent verbatim. An all-zero plaintext yields `"K= H=..."`.
- **Hex encoding:** nibble n < 10 maps to 0x30+n; otherwise it maps to 0x61+n−10. The most significant nibble is sent first.
- **States:**
  - IDLE: waits for `found_valid`.
  - EMIT: selects the byte for the current index.
  - WAIT_LOW: waits for `tx_ready` to go low.
  - WAIT_HIGH: waits for `tx_ready` to go high.
  - DONE: report complete.
- **IDLE:** when `found_valid` is sampled high, latch `found_text` and `found_hash`, clear the index to 0, clear `done`, and go to EMIT.
- **EMIT:**
  - If the index points to a skippable leading zero byte, increment the index and stay in EMIT. No send occurs; this costs one cycle per skipped byte.
  - Otherwise, if `tx_ready` is 1: register `tx_data`, assert `tx_send` for that cycle, and go to WAIT_LOW.
  - Otherwise, stay in EMIT.
- **WAIT_LOW:** deassert `tx_send`. Go to WAIT_HIGH when `tx_ready` is 0.
- **WAIT_HIGH:** when `tx_ready` is 1, increment the index. Go to DONE if the last byte was just sent, else go to EMIT.
- **DONE:** `done` is 1. `rewind` high clears the index and returns to EMIT using the latched data. `found_valid` high re-latches new data, as in IDLE.
- `found_valid` and `rewind` are ignored while `busy`.
- **Index counter:** 6 bits, never wraps; the terminal index is the message length minus 1.

## Timing
- **Reset values:** `tx_data` = 0x00, `tx_send` = 0, `busy` = 0, `done` = 0, state IDLE, index 0, latches 0.
- **Reset mid-transmission:** `tx_send` drops immediately (asynchronous reset) and no further bytes are sent.
- **Start latency:** `found_valid` is sampled at edge 0, `busy` = 1 after edge 0, and the earliest `tx_send` is high after edge 1 (assuming `tx_ready` = 1 and no skipped bytes).
- **Pulse width:** `tx_send` is high for exactly one cycle per byte. `tx_data` is stable from the pulse until the next pulse.
- **Handshake:** no second pulse until `tx_ready` has been observed low and then high. Minimum spacing between pulses is 3 cycles.
- **Completion:** `busy` falls and `done` rises on the same edge that exits WAIT_HIGH after the final LF.

## Structure
- **Package `md5_report_pkg`:** the state enum, ASCII constants (`'K'`, `'='`, `' '`, `'H'`, CR, LF), and `MSG_LEN` as a function of the parameters.
- **Sub-module `md5_hex_ascii`:** 4-bit nibble to 8-bit lowercase ASCII. Combinational; instantiated once on the selected nibble.
- **Byte select:** a mux on the index, covering the prefix, plaintext byte, separator, hex nibble and suffix.

## Test plan
- **Basic report:** `found_text` = 0x0000000000616263, `found_hash` = 0x900150983cd24fb0d6963f7d28e17f72, USART model drops ready 1 cycle after send and restores it after 10 cycles. Required: exactly 42 bytes, `"K=abc H=900150983cd24fb0d6963f7d28e17f72\r\n"`, then `done` = 1 and `busy` = 0.
- **Full-width / all-zero plaintext:**
  - 8 nonzero bytes 0x6161616161616161 → `"K=aaaaaaaa H=..."`, 47 bytes.
  - All-zero plaintext → `"K= H=..."`, 39 bytes.
- **Back-pressure:** hold `tx_ready` = 0 for 50 cycles mid-hash. Required: no extra `tx_send`, `tx_data` held, transmission resumes with the correct next char.
- **Ignore while busy / rewind:**
  - Pulse `found_valid` with different data while busy → no change in output stream.
  - `rewind` in DONE → identical 42-byte stream resent.
  - `rewind` while busy → ignored.
- **Reset mid-stream:** assert `reset` during the 10th byte. Required: `tx_send` = 0 immediately, `busy` = 0, `done` = 0, and the next `found_valid` restarts from `'K'`.

Source files
------------

// File: rtl/md5_report_pkg.sv
// Shared types and constants for the MD5 result reporter: FSM states,
// ASCII framing characters and the report length.
package md5_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DONE
  } state_t;

  localparam int IDX_W = 6;

  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_H  = 8'h48;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // "K=" + plaintext slots + " H=" + hex digits + CR LF; skipped leading
  // zero bytes still occupy an index slot, so the length is fixed.
  function automatic int msg_len(input int text_bytes, input int hash_bits);
    return 2 + text_bytes + 3 + hash_bits / 4 + 2;
  endfunction

endpackage

// File: rtl/md5_hex_ascii.sv
// Converts one nibble to its lowercase ASCII hex digit.
module md5_hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end

endmodule

// File: rtl/md5_result_reporter.sv
// Latches an MD5 search hit and streams "K=<text> H=<hex>\r\n" to the USART
// one byte at a time using its send/ready handshake.
module md5_result_reporter
  import md5_report_pkg::*;
#(
  parameter int TEXT_BYTES = 8,
  parameter int HASH_BITS  = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    found_valid,
  input  logic [8*TEXT_BYTES-1:0] found_text,
  input  logic [HASH_BITS-1:0]    found_hash,
  input  logic                    rewind,
  output logic [7:0]              tx_data,
  output logic                    tx_send,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int MSG_LEN  = msg_len(TEXT_BYTES, HASH_BITS);
  localparam int NIBBLES  = HASH_BITS / 4;
  localparam int TEXT_OFS = 2;
  localparam int SEP_OFS  = TEXT_OFS + TEXT_BYTES;
  localparam int HASH_OFS = SEP_OFS + 3;
  localparam int CR_IDX   = HASH_OFS + NIBBLES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t state, state_next;
  logic [IDX_W-1:0] index, index_next;
  logic [7:0] tx_data_next;
  logic tx_send_next;
  logic done_next;
  logic latch;

  logic [8*TEXT_BYTES-1:0] text_q;
  logic [HASH_BITS-1:0]    hash_q;

  logic [7:0] text_byte [TEXT_BYTES];
  logic [TEXT_BYTES-1:0] lead_zero;
  logic zero_run;

  logic [3:0] sel_nibble;
  logic [7:0] hex_char;
  logic [7:0] sel_byte;
  logic skip;
  int pos;

  assign pos  = int'(index);
  assign busy = (state == ST_EMIT) || (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);

  // lead_zero[i] is set when byte i and every byte before it are zero.
  always_comb begin
    zero_run = 1'b1;
    lead_zero = '0;
    for (int i = 0; i < TEXT_BYTES; i++) begin
      text_byte[i] = text_q[8*(TEXT_BYTES-1-i) +: 8];
      zero_run = zero_run & (text_byte[i] == 8'h00);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    sel_nibble = 4'h0;
    for (int j = 0; j < NIBBLES; j++) begin
      if (pos == HASH_OFS + j) sel_nibble = hash_q[HASH_BITS-1-4*j -: 4];
    end
  end

  md5_hex_ascii u_hex (
    .nibble (sel_nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    sel_byte = 8'h00;
    skip = 1'b0;
    if (pos == 0) begin
      sel_byte = ASCII_K;
    end else if (pos == 1) begin
      sel_byte = ASCII_EQ;
    end else if (pos >= TEXT_OFS && pos < SEP_OFS) begin
      for (int i = 0; i < TEXT_BYTES; i++) begin
        if (pos == TEXT_OFS + i) begin
          sel_byte = text_byte[i];
          skip = lead_zero[i];
        end
      end
    end else if (pos == SEP_OFS) begin
      sel_byte = ASCII_SP;
    end else if (pos == SEP_OFS + 1) begin
      sel_byte = ASCII_H;
    end else if (pos == SEP_OFS + 2) begin
      sel_byte = ASCII_EQ;
    end else if (pos >= HASH_OFS && pos < CR_IDX) begin
      sel_byte = hex_char;
    end else if (pos == CR_IDX) begin
      sel_byte = ASCII_CR;
    end else begin
      sel_byte = ASCII_LF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      index   <= '0;
      tx_data <= 8'h00;
      tx_send <= 1'b0;
      done    <= 1'b0;
      text_q  <= '0;
      hash_q  <= '0;
    end else begin
      state   <= state_next;
      index   <= index_next;
      tx_data <= tx_data_next;
      tx_send <= tx_send_next;
      done    <= done_next;
      if (latch) begin
        text_q <= found_text;
        hash_q <= found_hash;
      end
    end
  end

  // New hits take priority over rewind once the report has finished.
  always_comb begin
    state_next   = state;
    index_next   = index;
    tx_data_next = tx_data;
    tx_send_next = 1'b0;
    done_next    = done;
    latch        = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (found_valid) begin
          latch      = 1'b1;
          index_next = '0;
          done_next  = 1'b0;
          state_next = ST_EMIT;
        end else if (state == ST_DONE && rewind) begin
          index_next = '0;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (skip) begin
          index_next = index + IDX_W'(1);
        end else if (tx_ready) begin
          tx_data_next = sel_byte;
          tx_send_next = 1'b1;
          state_next   = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!tx_ready) state_next = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (tx_ready) begin
          if (index == LAST_IDX) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            index_next = index + IDX_W'(1);
            state_next = ST_EMIT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md5_result_reporter.sv
// Randomized self-checking bench for md5_result_reporter with a behavioural
// USART model and a string-level model of the expected report.
module tb_md5_result_reporter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic found_valid = 1'b0;
  logic [63:0] found_text = '0;
  logic [127:0] found_hash = '0;
  logic rewind = 1'b0;
  logic [7:0] tx_data;
  logic tx_send;
  logic tx_ready;
  logic busy;
  logic done;

  logic usart_ready = 1'b1;
  logic stall = 1'b0;
  int usart_delay = 10;
  int usart_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_send = 1'b0;
  logic [7:0] rx_q[$];
  int send_count = 0;
  int proto_err = 0;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0]  TEXT_ABC = 64'h0000000000616263;
  localparam logic [127:0] HASH_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;

  assign tx_ready = usart_ready & ~stall;

  always #5 clk = ~clk;

  md5_result_reporter dut (
    .clk         (clk),
    .reset       (reset),
    .found_valid (found_valid),
    .found_text  (found_text),
    .found_hash  (found_hash),
    .rewind      (rewind),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  // USART model: drops ready right after a send, restores it usart_delay cycles later.
  always @(negedge clk) begin
    if (reset) begin
      usart_ready = 1'b1;
      usart_cnt = 0;
      prev_send = 1'b0;
      last_data = 8'h00;
    end else begin
      if (tx_send) begin
        rx_q.push_back(tx_data);
        send_count++;
        if (!tx_ready) proto_err++;
        if (prev_send) proto_err++;
        usart_ready = 1'b0;
        usart_cnt = usart_delay;
        last_data = tx_data;
      end else begin
        if (tx_data !== last_data) proto_err++;
        if (usart_cnt > 0) begin
          usart_cnt--;
          if (usart_cnt == 0) usart_ready = 1'b1;
        end
      end
      prev_send = tx_send;
    end
  end

  function automatic string str_hex(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h", s[i])};
    return r;
  endfunction

  function automatic string expected_hex(input logic [63:0] t, input logic [127:0] h);
    string r;
    bit started = 1'b0;
    logic [7:0] b;
    r = str_hex("K=");
    for (int i = 7; i >= 0; i--) begin
      b = t[8*i +: 8];
      if (b != 8'h00) started = 1'b1;
      if (started) r = {r, $sformatf("%02h", b)};
    end
    r = {r, str_hex(" H="), str_hex($sformatf("%032h", h)), "0d0a"};
    return r;
  endfunction

  function automatic string actual_hex();
    string r = "";
    for (int i = 0; i < rx_q.size(); i++) r = {r, $sformatf("%02h", rx_q[i])};
    return r;
  endfunction

  task automatic clear_capture();
    @(posedge clk);
    #1;
    rx_q.delete();
    send_count = 0;
    proto_err = 0;
  endtask

  task automatic launch(input logic [63:0] t, input logic [127:0] h);
    @(negedge clk);
    found_text = t;
    found_hash = h;
    found_valid = 1'b1;
    @(negedge clk);
    found_valid = 1'b0;
  endtask

  task automatic wait_finished(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sends(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (send_count >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++;
    if (tx_send !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_send: got %b want 0", tx_send); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    string exp_s, act_s;
    clear_capture();
    @(negedge clk);
    found_text = TEXT_ABC;
    found_hash = HASH_ABC;
    found_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || tx_send !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_edge0: busy=%b tx_send=%b want busy=1 tx_send=0", busy, tx_send);
    end
    @(negedge clk);
    found_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tx_send !== 1'b1 || tx_data !== 8'h4B) begin
      failures++;
      $display("[TB] FAIL basic_edge1: tx_send=%b tx_data=%h want 1/4b", tx_send, tx_data);
    end
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL basic_timeout: report did not finish"); end
    exp_s = expected_hex(TEXT_ABC, HASH_ABC);
    act_s = actual_hex();
    checks++;
    if (rx_q.size() != 42) begin failures++; $display("[TB] FAIL basic_len: got %0d want 42", rx_q.size()); end
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL basic_stream: got %s want %s", act_s, exp_s); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_final: done=%b busy=%b want 1/0", done, busy);
    end
    checks++;
    if (proto_err != 0) begin failures++; $display("[TB] FAIL basic_protocol: got %0d errors want 0", proto_err); end
  endtask

  task automatic test_stream(input string name, input logic [63:0] t, input logic [127:0] h, input int len);
    bit ok;
    string exp_s, act_s;
    clear_capture();
    launch(t, h);
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL %s_timeout: report did not finish", name); end
    exp_s = expected_hex(t, h);
    act_s = actual_hex();
    checks++;
    if (rx_q.size() != len) begin failures++; $display("[TB] FAIL %s_len: got %0d want %0d", name, rx_q.size(), len); end
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL %s_stream: got %s want %s", name, act_s, exp_s); end
    checks++;
    if (proto_err != 0) begin failures++; $display("[TB] FAIL %s_protocol: got %0d errors want 0", name, proto_err); end
  endtask

  task automatic test_full_width();
    test_stream("full_width", 64'h6161616161616161, HASH_ABC, 47);
  endtask

  task automatic test_all_zero();
    test_stream("all_zero", 64'h0, 128'h0123456789abcdeffedcba9876543210, 39);
  endtask

  task automatic test_back_pressure();
    bit ok;
    int sc;
    logic [7:0] held;
    string exp_s, act_s;
    clear_capture();
    launch(TEXT_ABC, HASH_ABC);
    wait_sends(20, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL bp_reach: only %0d bytes sent", send_count); end
    @(posedge clk);
    #2;
    stall = 1'b1;
    sc = send_count;
    held = tx_data;
    repeat (50) @(negedge clk);
    checks++;
    if (send_count != sc) begin failures++; $display("[TB] FAIL bp_no_send: got %0d sends want %0d", send_count, sc); end
    checks++;
    if (tx_data !== held) begin failures++; $display("[TB] FAIL bp_hold: tx_data %h want %h", tx_data, held); end
    @(posedge clk);
    #2;
    stall = 1'b0;
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL bp_timeout: report did not finish"); end
    exp_s = expected_hex(TEXT_ABC, HASH_ABC);
    act_s = actual_hex();
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL bp_stream: got %s want %s", act_s, exp_s); end
    checks++;
    if (proto_err != 0) begin failures++; $display("[TB] FAIL bp_protocol: got %0d errors want 0", proto_err); end
  endtask

  task automatic test_ignore_busy();
    bit ok;
    string exp_s, act_s;
    clear_capture();
    launch(TEXT_ABC, HASH_ABC);
    wait_sends(5, ok);
    @(negedge clk);
    found_text = 64'h7a7a7a7a7a7a7a7a;
    found_hash = ~HASH_ABC;
    found_valid = 1'b1;
    @(negedge clk);
    found_valid = 1'b0;
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL ignore_timeout: report did not finish"); end
    exp_s = expected_hex(TEXT_ABC, HASH_ABC);
    act_s = actual_hex();
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL ignore_stream: got %s want %s", act_s, exp_s); end
  endtask

  task automatic test_rewind_busy();
    bit ok;
    string exp_s, act_s;
    clear_capture();
    launch(TEXT_ABC, HASH_ABC);
    wait_sends(3, ok);
    @(negedge clk);
    rewind = 1'b1;
    repeat (2) @(negedge clk);
    rewind = 1'b0;
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL rewind_busy_timeout: report did not finish"); end
    exp_s = expected_hex(TEXT_ABC, HASH_ABC);
    act_s = actual_hex();
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL rewind_busy_stream: got %s want %s", act_s, exp_s); end
  endtask

  task automatic test_rewind_done();
    bit ok;
    string exp_s, act_s;
    clear_capture();
    @(negedge clk);
    rewind = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rewind_start: busy=%b done=%b want 1/1", busy, done);
    end
    @(negedge clk);
    rewind = 1'b0;
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL rewind_timeout: report did not finish"); end
    exp_s = expected_hex(TEXT_ABC, HASH_ABC);
    act_s = actual_hex();
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL rewind_stream: got %s want %s", act_s, exp_s); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    string exp_s, act_s;
    clear_capture();
    launch(TEXT_ABC, HASH_ABC);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (tx_send && send_count == 9) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL reset_mid_reach: 10th byte not seen, %0d sent", send_count); end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_send !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: tx_send=%b busy=%b done=%b want 0/0/0", tx_send, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_capture();
    repeat (20) @(negedge clk);
    checks++;
    if (send_count != 0) begin failures++; $display("[TB] FAIL reset_mid_silent: got %0d sends want 0", send_count); end
    launch(TEXT_ABC, HASH_ABC);
    wait_finished(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL reset_mid_timeout: report did not finish"); end
    checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 8'h4B) begin
      failures++;
      $display("[TB] FAIL reset_mid_first: got %0d bytes, first %h want 4b", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    exp_s = expected_hex(TEXT_ABC, HASH_ABC);
    act_s = actual_hex();
    checks++;
    if (act_s != exp_s) begin failures++; $display("[TB] FAIL reset_mid_stream: got %s want %s", act_s, exp_s); end
  endtask

  task automatic test_random();
    bit ok;
    int lead;
    logic [63:0] t;
    logic [127:0] h;
    string exp_s, act_s;
    for (int iter = 0; iter < 6; iter++) begin
      lead = $urandom_range(0, 8);
      t = '0;
      for (int i = 0; i < 8; i++) begin
        if (i == lead) t[8*(7-i) +: 8] = 8'($urandom_range(1, 255));
        else if (i > lead) t[8*(7-i) +: 8] = 8'($urandom_range(0, 255));
      end
      h = {$urandom, $urandom, $urandom, $urandom};
      usart_delay = $urandom_range(1, 12);
      clear_capture();
      launch(t, h);
      wait_finished(ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL random%0d_timeout: report did not finish", iter); end
      exp_s = expected_hex(t, h);
      act_s = actual_hex();
      checks++;
      if (act_s != exp_s) begin failures++; $display("[TB] FAIL random%0d_stream: got %s want %s", iter, act_s, exp_s); end
      checks++;
      if (proto_err != 0) begin failures++; $display("[TB] FAIL random%0d_protocol: got %0d errors want 0", iter, proto_err); end
    end
    usart_delay = 10;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_width();
    test_all_zero();
    test_back_pressure();
    test_ignore_busy();
    test_rewind_busy();
    test_rewind_done();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
